// File: rtl/mux8_arb_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    // Output stage state: IDLE = stage empty, HOLD = stage holds a word not yet taken.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Converts a one-hot (or all-zero) vector to its bit index. All-zero returns 0.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back by adding ptr.
module rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   win
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   rot_oh;

    // Rotate, isolate lowest set bit, and map back to an absolute index.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[NUM_REQ-1:0];
        rot_oh  = req_rot & (~req_rot + NUM_REQ'(1));
        win     = onehot_to_idx(rot_oh) + ptr;
        any     = |req;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the 8:1 mux select, with a registered
// valid/ready output stage and a one-cycle grant pulse to the winner.
//
// state | meaning
// IDLE  | output stage empty, next request is captured immediately
// HOLD  | out_data holds a word; a new capture needs out_ready
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] din,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      busy
);

    arb_state_e           state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 valid_q, valid_d;
    logic [DATA_W-1:0]    data_q, data_d;

    logic                 any_req;
    logic [SEL_W-1:0]     win;
    logic [DATA_W-1:0]    din_win;
    logic                 load;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (any_req),
        .win (win)
    );

    // Select the winner's data slice from the packed input bus.
    always_comb begin
        din_win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == SEL_W'(i)) begin
                din_win = din[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state: capture on load, drain on handshake, otherwise hold everything.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = '0;
        valid_d = valid_q;
        data_d  = data_q;
        load    = any_req && ((state_q == IDLE) || out_ready);

        if (load) begin
            sel_d   = win;
            data_d  = din_win;
            valid_d = 1'b1;
            gnt_d   = NUM_REQ'(1) << win;
            ptr_d   = win + SEL_W'(1);
            state_d = HOLD;
        end else if ((state_q == HOLD) && out_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end
    end

    // State, pointer and output registers; reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = valid_q;

endmodule
